// File: rtl/line_doubler.sv
// Line doubler: ping-pong line buffer re-emitting each input line twice at double pixel rate.
// Build option: define SCANLINES_EN to darken the repeat copy of each line (scanlines select).
module line_doubler #(
    parameter int LINE_LENGTH = 896,
    parameter bit HALF_DEPTH  = 1'b1,
    localparam int DW = HALF_DEPTH ? 3 : 6
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix_in,
    input  logic          ce_pix_out,
    input  logic          scandoubler_disable,
    input  logic [1:0]    scanlines,
    input  logic [DW-1:0] R,
    input  logic [DW-1:0] G,
    input  logic [DW-1:0] B,
    input  logic          HSync,
    input  logic          VSync,
    output logic [DW-1:0] R_out,
    output logic [DW-1:0] G_out,
    output logic [DW-1:0] B_out,
    output logic          HS_out,
    output logic          VS_out,
    output logic          line_odd
);

    localparam int AW = $clog2(LINE_LENGTH + 1);
    localparam int IW = $clog2(LINE_LENGTH);
    localparam int PW = 3 * DW;
    localparam logic [AW-1:0] LEN_MAX = AW'(LINE_LENGTH);
    localparam logic [AW-1:0] LEN_MIN = AW'(16);

    logic [PW-1:0] line_buf [0:1][0:LINE_LENGTH-1];

    logic          hs_q;
    logic          vs_q;
    logic          hs_rise;
    logic          hs_fall;
    logic          buf_sel;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] line_len;
    logic [AW-1:0] hs_cnt;
    logic [AW-1:0] hs_width;
    logic          wr_en;
    logic          wr_half;
    logic [IW-1:0] wr_idx;
    logic [PW-1:0] rd_data;
    logic          rd_wrap;
    logic          rd_zero;
    logic [DW-1:0] pix_r;
    logic [DW-1:0] pix_g;
    logic [DW-1:0] pix_b;

    assign hs_rise = ce_pix_in & HSync & ~hs_q;
    assign hs_fall = ce_pix_in & ~HSync & hs_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (ce_pix_in) begin
            hs_q <= HSync;
            vs_q <= VSync;
        end
    end

    // Write side: the rise pixel lands at address 0 of the new half, so wr_addr is the line's pixel count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_addr  <= '0;
            buf_sel  <= 1'b0;
            line_len <= LEN_MAX;
            hs_cnt   <= '0;
            hs_width <= '0;
        end else if (ce_pix_in) begin
            if (hs_rise) begin
                buf_sel <= ~buf_sel;
                wr_addr <= AW'(1);
                hs_cnt  <= AW'(1);
                if (wr_addr >= LEN_MIN) begin
                    line_len <= wr_addr;
                end
            end else begin
                if (wr_addr < LEN_MAX) begin
                    wr_addr <= wr_addr + AW'(1);
                end
                if (HSync && hs_cnt != '1) begin
                    hs_cnt <= hs_cnt + AW'(1);
                end
            end
            if (hs_fall) begin
                hs_width <= hs_cnt;
            end
        end
    end

    assign wr_half = hs_rise ? ~buf_sel : buf_sel;
    assign wr_idx  = hs_rise ? '0 : wr_addr[IW-1:0];
    assign wr_en   = ce_pix_in & (hs_rise | (wr_addr < LEN_MAX));

    // NOTE: the line buffer has no reset so it maps onto block RAM; stale contents only show for one line.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            line_buf[wr_half][wr_idx] <= {R, G, B};
        end
        rd_data <= line_buf[~buf_sel][rd_addr[IW-1:0]];
    end

    assign rd_wrap = rd_addr >= (line_len - AW'(1));
    assign rd_zero = hs_rise | (ce_pix_out & rd_wrap);

    // Read side: input HSync rise resynchronises the read pointer ahead of any wrap.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_addr  <= '0;
            line_odd <= 1'b0;
        end else begin
            if (hs_rise) begin
                rd_addr  <= '0;
                line_odd <= 1'b0;
            end else if (ce_pix_out) begin
                if (rd_wrap) begin
                    rd_addr  <= '0;
                    line_odd <= ~line_odd;
                end else begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
            if (scandoubler_disable) begin
                line_odd <= 1'b0;
            end
        end
    end

`ifdef SCANLINES_EN
    function automatic logic [DW-1:0] dim(input logic [DW-1:0] v, input logic [1:0] sel);
        case (sel)
            2'b01:   dim = v >> 1;
            2'b10:   dim = v >> 2;
            2'b11:   dim = (v >> 1) + (v >> 2);
            default: dim = v;
        endcase
    endfunction
`else
    logic scanlines_unused;
    assign scanlines_unused = ^scanlines;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pix_r = rd_data[PW-1 -: DW];
        pix_g = rd_data[2*DW-1 -: DW];
        pix_b = rd_data[DW-1:0];
`ifdef SCANLINES_EN
        if (line_odd) begin
            pix_r = dim(pix_r, scanlines);
            pix_g = dim(pix_g, scanlines);
            pix_b = dim(pix_b, scanlines);
        end
`endif
    end

    // Outputs: registered passthrough in bypass, otherwise one ce_pix_out behind the read address.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            R_out  <= '0;
            G_out  <= '0;
            B_out  <= '0;
            HS_out <= 1'b0;
            VS_out <= 1'b0;
        end else if (scandoubler_disable) begin
            if (ce_pix_in) begin
                R_out  <= R;
                G_out  <= G;
                B_out  <= B;
                HS_out <= HSync;
                VS_out <= VSync;
            end
        end else begin
            if (ce_pix_out) begin
                R_out  <= pix_r;
                G_out  <= pix_g;
                B_out  <= pix_b;
                HS_out <= rd_addr < hs_width;
            end
            if (rd_zero) begin
                VS_out <= vs_q;
            end
        end
    end

endmodule

// File: tb/tb_line_doubler.sv
// Scoreboard bench for line_doubler: a line-level reference model queues expected pixels,
// and a monitor compares them against every ce_pix_out output.
`timescale 1ns/1ps
module tb_line_doubler;

    localparam int LL = 896;
    localparam int DW = 3;
    localparam int PW = 3 * DW;
`ifdef SCANLINES_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce_pix_in;
    logic          ce_pix_out;
    logic          scandoubler_disable;
    logic [1:0]    scanlines;
    logic [DW-1:0] R, G, B;
    logic          HSync, VSync;
    logic [DW-1:0] R_out, G_out, B_out;
    logic          HS_out, VS_out, line_odd;

    always #5 clk_sys = ~clk_sys;

    line_doubler #(.LINE_LENGTH(LL), .HALF_DEPTH(1'b1)) dut (
        .clk_sys             (clk_sys),
        .reset               (reset),
        .ce_pix_in           (ce_pix_in),
        .ce_pix_out          (ce_pix_out),
        .scandoubler_disable (scandoubler_disable),
        .scanlines           (scanlines),
        .R                   (R),
        .G                   (G),
        .B                   (B),
        .HSync               (HSync),
        .VSync               (VSync),
        .R_out               (R_out),
        .G_out               (G_out),
        .B_out               (B_out),
        .HS_out              (HS_out),
        .VS_out              (VS_out),
        .line_odd            (line_odd)
    );

    typedef struct packed {
        logic          chk;
        logic [PW-1:0] rgb;
        logic          hs;
        logic          odd;
        logic          vs;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: completed lines live in two line images; output position is
    // simply the count of output ticks since the last input HSync rise, modulo line length.
    logic [PW-1:0] m_buf [2][LL];
    int   m_rises, m_wcount, m_len, m_n, m_hs_cnt, m_hs_width;
    logic m_hs_q, m_vs_q, m_vs_out;
    logic cur_vs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] shade(input logic [DW-1:0] v, input logic odd,
                                            input logic [1:0] sel);
        int x;
        x = int'(v);
        if (SCAN_ON && odd) begin
            case (sel)
                2'd1:    x = x / 2;
                2'd2:    x = x / 4;
                2'd3:    x = x / 2 + x / 4;
                default: x = x;
            endcase
        end
        return DW'(x);
    endfunction

    task automatic model_reset();
        m_rises    = 0;
        m_wcount   = 0;
        m_len      = LL;
        m_n        = 0;
        m_hs_cnt   = 0;
        m_hs_width = 0;
        m_hs_q     = 1'b0;
        m_vs_q     = 1'b0;
        m_vs_out   = 1'b0;
    endtask

    task automatic push_dummy();
        exp_t e;
        e = '0;
        sb_q.push_back(e);
    endtask

    task automatic out_tick(input logic resync, input logic vs_now);
        int            pos;
        logic          odd;
        logic [PW-1:0] px;
        exp_t          e;
        if (resync) m_n = 0;
        else        m_n++;
        pos = m_n % m_len;
        odd = ((m_n / m_len) % 2) == 1;
        if (pos == 0) m_vs_out = vs_now;
        px    = m_buf[(m_rises + 1) % 2][pos];
        e.chk = (m_rises >= 2) && !scandoubler_disable;
        e.rgb = {shade(px[PW-1 -: DW], odd, scanlines),
                 shade(px[2*DW-1 -: DW], odd, scanlines),
                 shade(px[DW-1:0], odd, scanlines)};
        e.hs  = pos < m_hs_width;
        e.odd = odd;
        e.vs  = m_vs_out;
        sb_q.push_back(e);
    endtask

    // One input pixel period: 4 clocks, ce_pix_out on the 1st and 3rd, ce_pix_in on the 1st.
    task automatic pix(input logic [DW-1:0] r, g, b, input logic hs, vs);
        logic rise, fall, vs_before;
        @(negedge clk_sys);
        R = r; G = g; B = b; HSync = hs; VSync = vs;
        ce_pix_in = 1'b1; ce_pix_out = 1'b1;
        vs_before = m_vs_q;
        rise = hs & ~m_hs_q;
        fall = ~hs & m_hs_q;
        if (rise) begin
            if (m_wcount >= 16) m_len = m_wcount;
            m_rises++;
            m_wcount = 0;
            m_hs_cnt = 1;
        end else if (hs) begin
            m_hs_cnt++;
        end
        if (fall) m_hs_width = m_hs_cnt;
        if (m_wcount < LL) begin
            m_buf[m_rises % 2][m_wcount] = {r, g, b};
            m_wcount++;
        end
        m_hs_q = hs;
        m_vs_q = vs;
        out_tick(rise, vs_before);
        @(negedge clk_sys);
        ce_pix_in = 1'b0; ce_pix_out = 1'b0;
        @(negedge clk_sys);
        ce_pix_out = 1'b1;
        out_tick(1'b0, m_vs_q);
        @(negedge clk_sys);
        ce_pix_out = 1'b0;
    endtask

    task automatic line(input int len, input int hsw, input logic ramp, input logic vs_flip);
        for (int t = 0; t < len; t++) begin
            logic [DW-1:0] r, g, b;
            if (ramp) begin
                r = DW'(t); g = r; b = r;
            end else begin
                r = DW'($urandom); g = DW'($urandom); b = DW'($urandom);
            end
            if (vs_flip && t == 100) cur_vs = ~cur_vs;
            pix(r, g, b, t < hsw, cur_vs);
        end
    endtask

    task automatic check_zero_outputs();
        check("rst_rgb", {R_out, G_out, B_out}, '0);
        check("rst_hs", HS_out, 1'b0);
        check("rst_vs", VS_out, 1'b0);
        check("rst_odd", line_odd, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            if (i > 0) check_zero_outputs();
            reset = 1'b1;
            if (i == 0) scanlines = 2'($urandom);
            HSync = ~HSync; VSync = ~VSync;
            ce_pix_in = 1'b1; ce_pix_out = 1'b1;
            push_dummy();
        end
        @(negedge clk_sys);
        check_zero_outputs();
        ce_pix_in = 1'b0; ce_pix_out = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: rgb/HS_out lag the read address by one ce_pix_out, line_odd/VS_out do not.
    initial begin : monitor
        exp_t prev, cur;
        logic have_prev;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(posedge clk_sys);
            if (ce_pix_out) begin
                #1;
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: got empty queue, expected an entry (t=%0t)", $time);
                    cur = '0;
                end else begin
                    cur = sb_q.pop_front();
                end
                if (have_prev && prev.chk && !reset && !scandoubler_disable) begin
                    check("rgb", {R_out, G_out, B_out}, prev.rgb);
                    check("hs_out", HS_out, prev.hs);
                end
                if (cur.chk && !reset) begin
                    check("line_odd", line_odd, cur.odd);
                    check("vs_out", VS_out, cur.vs);
                end
                prev = cur;
                have_prev = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        ce_pix_in = 1'b0; ce_pix_out = 1'b0;
        scandoubler_disable = 1'b0;
        scanlines = 2'b00;
        R = '0; G = '0; B = '0;
        HSync = 1'b0; VSync = 1'b0;
        cur_vs = 1'b0;
        model_reset();
        do_reset();

        repeat (3) line(448, 32, 1'b1, 1'b0);
        line(448, 32, 1'b0, 1'b1);
        line(448, 32, 1'b0, 1'b0);
        line(1000, 32, 1'b0, 1'b0);
        line(448, 32, 1'b0, 1'b1);
        line(5, 2, 1'b0, 1'b0);
        line(448, 32, 1'b0, 1'b0);
        line(448, 32, 1'b1, 1'b0);

        line(200, 32, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) line(448, $urandom_range(8, 60), 1'b0, i == 1);

        @(negedge clk_sys);
        scandoubler_disable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] r, g, b;
            logic hs, vs;
            r  = (i == 0) ? DW'(5) : DW'($urandom);
            g  = DW'($urandom);
            b  = DW'($urandom);
            hs = 1'($urandom);
            vs = 1'($urandom);
            pix(r, g, b, hs, vs);
            check("byp_rgb", {R_out, G_out, B_out}, {r, g, b});
            check("byp_hs", HS_out, hs);
            check("byp_vs", VS_out, vs);
            check("byp_odd", line_odd, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_doubler.md
Name: line_doubler

Overview:
- Downstream of the Spectrum video controller. Consumes its per-pixel colour plus HSync/VSync at the native 14 MHz pixel-enable rate.
- Emits every input line twice at double rate, giving a VGA-rate (31 kHz) stream.
- Ping-pong line buffer: one half is written with the current input line while the other half is read out twice.
- Sits between the video controller colour output and the final VGA pins/OSD overlay.

Parameters:
LINE_LENGTH, 896, buffer depth per half; max input pixels per line (ce_pix_in ticks between HSync rises)
HALF_DEPTH, 1, 1 = 3-bit colour channels, 0 = 6-bit; DW = HALF_DEPTH ? 3 : 6

Ports:
clk_sys  in  1  master clock; single clock domain
reset  in  1  synchronous, active-high reset
ce_pix_in  in  1  input pixel enable (14 MHz equivalent)
ce_pix_out  in  1  output pixel enable, exactly 2x ce_pix_in rate
scandoubler_disable  in  1  1 = bypass doubling
scanlines  in  2  scanline darkening select (used only with SCANLINES_EN)
R, G, B  in  DW each  input colour
HSync, VSync  in  1 each  input syncs, active-high
R_out, G_out, B_out  out  DW each  output colour
HS_out, VS_out  out  1 each  output syncs, active-high
line_odd  out  1  1 during the second (repeat) output copy of a line

Behaviour:
- Reset values:
  - all outputs 0; wr_addr = rd_addr = 0; buf_sel = 0.
  - line_len = LINE_LENGTH; hs_width = 0; line_odd = 0.
- Input sampling:
  - HSync/VSync are sampled only on ce_pix_in.
  - An HSync rise is a ce_pix_in tick with HSync = 1 and the previous sample = 0.
- Write side (on ce_pix_in):
  - Write {R,G,B} to buffer[buf_sel][wr_addr] when wr_addr < LINE_LENGTH; wr_addr saturates at LINE_LENGTH and further pixels are dropped.
  - On an HSync rise:
    - line_len <= min(wr_addr, LINE_LENGTH) if that value >= 16; otherwise keep the previous line_len (glitch reject).
    - wr_addr <= 0; buf_sel toggles.
    - The pixel on that tick is written at address 0 of the new half.
- HSync width:
  - hs_cnt counts ce_pix_in ticks while HSync = 1 and clears on the rise.
  - hs_width <= hs_cnt on the HSync fall.
- Read side (on ce_pix_out):
  - Read from buffer[~buf_sel][rd_addr].
  - rd_addr increments; when rd_addr == line_len-1 it wraps to 0 and line_odd toggles.
  - An input HSync rise forces rd_addr <= 0 and line_odd <= 0. This resync takes priority over a simultaneous wrap.
  - Net effect: two output lines per input line, with output lag of exactly one input line.
- Output timing:
  - Buffer read is 1 clk_sys latency.
  - R_out/G_out/B_out/HS_out update on the ce_pix_out following the one that presented rd_addr, giving a fixed 1 ce_pix_out pixel latency. HS_out uses the same delay, so sync and colour stay aligned.
  - HS_out = (rd_addr < hs_width), evaluated with the same delay.
  - VS_out <= current sampled VSync, updated only when rd_addr becomes 0 (wrap or resync), so VS edges are line-aligned.
- Bypass (scandoubler_disable = 1):
  - On ce_pix_in, outputs <= {R,G,B,HSync,VSync}: one-tick registered passthrough.
  - line_odd = 0; buffer writes continue.
  - Switching mode takes effect on the next ce_pix_in/ce_pix_out tick with no reset needed; at most one corrupted line.
- Reset mid-line: all state returns to reset values on the next clk_sys. The first output line after reset may show stale buffer contents; buffer RAM is not cleared.

Optional Feature:
- Macro: SCANLINES_EN.
- Defined: on output lines with line_odd = 1, each colour channel is attenuated:
  - scanlines = 00: unchanged
  - scanlines = 01: value >> 1 (50%)
  - scanlines = 10: value >> 2 (25%)
  - scanlines = 11: (value >> 1) + (value >> 2) (75%)
  - Syncs are unaffected; attenuation never applies in bypass.
- Undefined: the scanlines port is present but ignored; both copies are identical.

Test Plan:
- Reset: assert reset for 3 clk with syncs toggling -> all outputs 0, line_odd = 0, HS_out = 0.
- Ramp line: 448 input pixels per line, colour = addr[2:0], HSync high for 32 ticks -> next input-line period shows two output lines, each 448 pixels of the identical ramp; HS_out high for 32 ce_pix_out ticks at each line start; line_odd = 0 then 1.
- Overlong line: 1000 ticks between HSync rises with LINE_LENGTH = 896 -> line_len = 896, no address wrap into other half, output repeats pixels 0..895.
- Glitch: two HSync rises 5 ticks apart -> line_len keeps previous 448; rd_addr still resyncs to 0.
- Bypass: scandoubler_disable = 1, R = 5 on one ce_pix_in -> R_out = 5 on next ce_pix_in; line_odd = 0.
- SCANLINES_EN, scanlines = 01, input R = 6 -> R_out = 6 on first copy, 3 on second copy.
